// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, 32 iterations.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (divide by zero, overflow, zero multiply) finish at E0.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  select_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_out
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;       // multiplicand (MUL*) or divisor (DIV/REM) magnitude
    logic [63:0] acc_q, acc_d;         // product accumulator, or dividend/quotient in low word
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_val_q, spec_val_d;
    logic [31:0] result_q, result_d;

    // Accept-side decode of the incoming operation
    logic        a_signed, b_signed, a_neg, b_neg, is_div_in, is_rem_in, sign_in;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, mul_zero, special_in;
    logic [31:0] special_val;

    always_comb begin
        a_signed = (select_op == OpMul) || (select_op == OpMulh) || (select_op == OpMulhsu) ||
                   (select_op == OpDiv) || (select_op == OpRem);
        b_signed = (select_op == OpMul) || (select_op == OpMulh) ||
                   (select_op == OpDiv) || (select_op == OpRem);
        a_neg     = a_signed & operand_a[31];
        b_neg     = b_signed & operand_b[31];
        a_mag     = a_neg ? (~operand_a + 32'd1) : operand_a;
        b_mag     = b_neg ? (~operand_b + 32'd1) : operand_b;
        is_div_in = select_op[2];
        is_rem_in = select_op[2] & select_op[1];
        sign_in   = is_rem_in ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div_in && (operand_b == 32'd0);
        div_ovf   = ((select_op == OpDiv) || (select_op == OpRem)) &&
                    (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
        mul_zero  = !is_div_in && ((operand_a == 32'd0) || (operand_b == 32'd0));
        special_in = div_zero | div_ovf | mul_zero;
        special_val = 32'd0;
        if (div_zero) begin
            special_val = is_rem_in ? operand_a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_val = is_rem_in ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of each datapath, plus sign fixup of the final value
    logic [32:0] mul_sum, part_rem;
    logic [63:0] mul_acc, div_acc, product;
    logic [31:0] div_rem, quot, remv, final_val;
    logic        q_bit;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        mul_acc  = {mul_sum, acc_q[31:1]};
        part_rem = {rem_q, acc_q[31]};
        q_bit    = part_rem >= {1'b0, opnd_q};
        div_rem  = q_bit ? 32'(part_rem - {1'b0, opnd_q}) : part_rem[31:0];
        div_acc  = {32'd0, acc_q[30:0], q_bit};
        product  = neg_q ? (~mul_acc + 64'd1) : mul_acc;
        quot     = neg_q ? (~div_acc[31:0] + 32'd1) : div_acc[31:0];
        remv     = neg_q ? (~div_rem + 32'd1) : div_rem;
        case (op_q)
            OpMul:                     final_val = product[31:0];
            OpMulh, OpMulhsu, OpMulhu: final_val = product[63:32];
            OpDiv, OpDivu:             final_val = quot;
            default:                   final_val = remv;
        endcase
        if (spec_q) begin
            final_val = spec_val_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StCalc;
                    op_d       = select_op;
                    opnd_d     = is_div_in ? b_mag : a_mag;
                    acc_d      = {32'd0, (is_div_in ? a_mag : b_mag)};
                    rem_d      = 32'd0;
                    cnt_d      = 5'd0;
                    neg_d      = sign_in;
                    spec_d     = special_in;
                    spec_val_d = special_val;
                    if (EarlyOut && special_in) begin
                        state_d  = StDone;
                        result_d = special_val;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                acc_d = op_q[2] ? div_acc : mul_acc;
                rem_d = op_q[2] ? div_rem : rem_q;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d  = StDone;
                    result_d = final_val;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= 3'd0;
            opnd_q     <= 32'd0;
            acc_q      <= 64'd0;
            rem_q      <= 32'd0;
            cnt_q      <= 5'd0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
        end
    end

    assign busy       = (state_q == StCalc);
    assign done       = (state_q == StDone);
    assign result_out = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit; honours MULDIV_EARLY_OUT_EN for latency expectations.
module tb_mul_div_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic        clk, rst_n, start, busy, done;
    logic [2:0]  select_op;
    logic [31:0] operand_a, operand_b, result_out;

    mul_div_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .select_op  (select_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .result_out (result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
        string       name;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    int   nv = 0;
    int   passed = 0;
    int   total = 0;

    function automatic void add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input bit spec, input string name);
        vecs[nv] = '{op, a, b, exp, spec, name};
        nv++;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        select_op = op;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optionally fires a stray start at inj.
    task automatic wait_done(input int inj, output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            if (inj > 0 && edges == inj) begin
                start     = 1'b1;
                select_op = 3'b000;
                operand_a = 32'd3;
                operand_b = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
    endtask

    int lat;
    int exp_lat;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        select_op = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;

        add(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        add(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min_min");
        add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        add(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1");
        add(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, "mul_shift4");
        add(3'b011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 1'b0, "mulhu_shift4");
        add(3'b000, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 1'b1, "mul_zero");
        add(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        add(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        add(3'b101, 32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7");
        add(3'b111, 32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7");
        add(3'b100, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, "div_m100_7");
        add(3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0, "rem_m100_7");
        add(3'b100, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100_m7");
        add(3'b110, 32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0, "rem_100_m7");
        add(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div_by_zero");
        add(3'b110, 32'd5,         32'd0,         32'd5,         1'b1, "rem_by_zero");
        add(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "divu_by_zero");
        add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf");

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full path is 32 edges after E0; early-out lands in DONE on E0 itself.
        for (int i = 0; i < nv; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, lat);
            exp_lat = (EarlyOut && vecs[i].spec) ? 0 : 32;
            check({vecs[i].name, "_result"}, result_out, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, exp_lat);
        end

        // Stray start mid-operation is ignored
        start_op(3'b101, 32'd100, 32'd7);
        wait_done(10, lat);
        check("ignore_start_result", result_out, 32'd14);
        check("ignore_start_latency", lat, 32);

        // start held through DONE: second op accepted with no idle cycle
        @(negedge clk);
        select_op = 3'b000;
        operand_a = 32'h0000_0007;
        operand_b = 32'hFFFF_FFFD;
        start     = 1'b1;
        @(posedge clk);
        #1;
        select_op = 3'b101;
        operand_a = 32'd100;
        operand_b = 32'd7;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_result", result_out, 32'hFFFF_FFEB);
        check("b2b_first_latency", lat, 32);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_no_gap", {31'd0, busy}, 32'd1);
        wait_done(0, lat);
        check("b2b_second_result", result_out, 32'd14);
        check("b2b_second_latency", lat, 32);

        // Asynchronous reset mid-operation
        start_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(3'b111, 32'd100, 32'd7);
        wait_done(0, lat);
        check("post_reset_result", result_out, 32'd2);
        check("post_reset_latency", lat, 32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
